// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access-size codes,
// FSM states and the alignment / legality checks.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Size lives in func3[1:0]; sign/zero selection in func3[2] does not affect alignment.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr);
        case (func3[1:0])
            2'b01:   return addr[0];
            2'b10:   return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic isStore, input logic [2:0] func3);
        if (isStore)
            return !(func3 inside {F3_SB, F3_SH, F3_SW});
        return func3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated store data, and
// extraction plus sign/zero extension of load data from the raw word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wrData,
    output logic [31:0] loadData
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign loadByte = rawWord[8*byteOff +: 8];
    assign loadHalf = byteOff[1] ? rawWord[31:16] : rawWord[15:0];

    // Narrow stores are replicated across the word; byte enables pick the live lanes.
    always_comb begin
        byteEn = 4'b0000;
        wrData = storeData;
        case (func3)
            F3_SB: begin
                byteEn = 4'b0001 << byteOff;
                wrData = {4{storeData[7:0]}};
            end
            F3_SH: begin
                byteEn = byteOff[1] ? 4'b1100 : 4'b0011;
                wrData = {2{storeData[15:0]}};
            end
            F3_SW:   byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    always_comb begin
        loadData = 32'h0;
        case (func3)
            F3_LB:   loadData = {{24{loadByte[7]}}, loadByte};
            F3_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_LW:   loadData = rawWord;
            F3_LBU:  loadData = {24'h0, loadByte};
            F3_LHU:  loadData = {16'h0, loadHalf};
            default: loadData = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl_ws.sv
// Data-memory controller with WAIT_STATES busy cycles, sized loads/stores and fault reporting.
// Defining DMEM_STATS_EN adds saturating load/store/fault counters (rd_count, wr_count, flt_count).
module dmem_ctrl_ws
    import dmem_pkg::*;
#(
    parameter int MEMORY_DEPTH  = 4096,
    parameter int ADDRESS_WIDTH = 32,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     write_En,
    input  logic                     read_En,
    input  logic [2:0]               func3_in,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [31:0]              data_in,
    output logic [31:0]              data_out,
    output logic                     ready,
    output logic                     done,
    output logic                     fault
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic [31:0]              flt_count
`endif
);

    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIM = ADDRESS_WIDTH'(MEMORY_DEPTH);

    logic [31:0] mem [MEMORY_DEPTH];

    state_e                   state;
    logic [3:0]               waitCnt;
    logic [ADDRESS_WIDTH-1:0] reqAddr;
    logic [2:0]               reqFunc3;
    logic [31:0]              reqData;
    logic                     reqStore;
    logic                     reqBoth;
    logic                     faultReg;

    logic                     idle, accept, goDone, isFault;
    logic [ADDRESS_WIDTH-1:0] curAddr;
    logic [2:0]               curFunc3;
    logic [31:0]              curData;
    logic                     curStore, curBoth;
    logic [IDX_W-1:0]         wordIdx;
    logic [31:0]              rawWord, wrData, loadData;
    logic [3:0]               byteEn;

    // With zero wait states the commit happens on the accepting edge, so the
    // access is taken straight from the inputs while idle.
    assign idle     = state == IDLE;
    assign accept   = idle & (read_En | write_En);
    assign curAddr  = idle ? address  : reqAddr;
    assign curFunc3 = idle ? func3_in : reqFunc3;
    assign curData  = idle ? data_in  : reqData;
    assign curStore = idle ? write_En : reqStore;
    assign curBoth  = idle ? (read_En & write_En) : reqBoth;
    assign wordIdx  = curAddr[IDX_W+1:2];
    assign rawWord  = mem[wordIdx];

    assign isFault = curBoth
                   | is_illegal(curStore, curFunc3)
                   | is_misaligned(curFunc3, curAddr[1:0])
                   | ((curAddr >> 2) >= DEPTH_LIM);

    assign goDone = (accept & (WAIT_STATES == 0)) | ((state == BUSY) & (waitCnt == 4'd0));

    dmem_lane_align uAlign (
        .func3    (curFunc3),
        .byteOff  (curAddr[1:0]),
        .storeData(curData),
        .rawWord  (rawWord),
        .byteEn   (byteEn),
        .wrData   (wrData),
        .loadData (loadData)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= IDLE;
            waitCnt  <= '0;
            reqAddr  <= '0;
            reqFunc3 <= '0;
            reqData  <= '0;
            reqStore <= 1'b0;
            reqBoth  <= 1'b0;
            faultReg <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    reqAddr  <= address;
                    reqFunc3 <= func3_in;
                    reqData  <= data_in;
                    reqStore <= write_En;
                    reqBoth  <= read_En & write_En;
                    waitCnt  <= 4'(WAIT_STATES - 1);
                    state    <= (WAIT_STATES == 0) ? DONE : BUSY;
                end
                BUSY: begin
                    if (waitCnt == 4'd0) state <= DONE;
                    else                 waitCnt <= waitCnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (goDone) begin
                faultReg <= isFault;
                if (isFault)        data_out <= '0;
                else if (!curStore) data_out <= loadData;
            end
        end
    end

    // Gated by rstN so a store abandoned by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (rstN && goDone && curStore && !isFault) begin
            for (int b = 0; b < WORD_BYTES; b++)
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
    end

    assign ready = idle;
    assign done  = state == DONE;
    assign fault = done & faultReg;

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rd_count  <= '0;
            wr_count  <= '0;
            flt_count <= '0;
        end else if (done) begin
            if (fault) begin
                if (flt_count != '1) flt_count <= flt_count + 32'd1;
            end else if (reqStore) begin
                if (wr_count != '1) wr_count <= wr_count + 32'd1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule
